// File: rtl/btn_pkg.sv
// Shared types and constants for the button conditioner: FSM states,
// channel indices (index order doubles as arbitration priority) and defaults.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } btn_state_t;

    typedef logic [1:0] ch_idx_t;

    localparam int NUM_CH = 3;
    localparam int CH_L   = 0;
    localparam int CH_R   = 1;
    localparam int CH_D   = 2;

    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_HOLD_CYCLES     = 2500000;
    localparam int DEF_REPEAT_DELAY    = 7500000;
    localparam int DEF_REPEAT_PERIOD   = 2500000;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One width for every timing counter, large enough for the biggest parameter.
    function automatic int counter_width(input int a, input int b, input int c, input int d);
        return $clog2(max_of(max_of(a, b), max_of(c, d))) + 1;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button-side bundle: raw push-buttons in, stretched requests, debounced
// levels and the accepted-event counter out.
interface button_conditioner_if;

    logic       btnL_raw;
    logic       btnD_raw;
    logic       btnR_raw;
    logic       buttonL;
    logic       buttonD;
    logic       buttonR;
    logic       levelL;
    logic       levelD;
    logic       levelR;
    logic [7:0] eventCount;

    modport slave (
        input  btnL_raw, btnD_raw, btnR_raw,
        output buttonL, buttonD, buttonR,
        output levelL, levelD, levelR,
        output eventCount
    );

    modport master (
        output btnL_raw, btnD_raw, btnR_raw,
        input  buttonL, buttonD, buttonR,
        input  levelL, levelD, levelR,
        input  eventCount
    );

endinterface

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer followed by a debounce counter that
// flips the level only after DEBOUNCE_CYCLES consecutive opposite samples.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CW              = counter_width(DEF_DEBOUNCE_CYCLES, DEF_HOLD_CYCLES,
                                                  DEF_REPEAT_DELAY, DEF_REPEAT_PERIOD)
) (
    input  logic CLK25M,
    input  logic Reset,
    input  logic raw,
    output logic level
);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge CLK25M or negedge Reset) begin
        if (!Reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Any sample matching the current level throws away the partial run.
    always_ff @(posedge CLK25M or negedge Reset) begin
        if (!Reset) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_2 == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level      <= sync_2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Three-channel button conditioner: debounce, per-channel press FSM, single
// owner request stretcher with L > R > D priority. Auto-repeat: BTN_AUTOREPEAT_EN.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic CLK25M,
    input  logic Reset,
    button_conditioner_if.slave bus
);

    localparam int CW = counter_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $fatal(1, "button_conditioner: timing parameters must be at least 1");
    end

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] level_vec;
    logic [NUM_CH-1:0] event_vec;

    assign raw_vec[CH_L] = bus.btnL_raw;
    assign raw_vec[CH_R] = bus.btnR_raw;
    assign raw_vec[CH_D] = bus.btnD_raw;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CW             (CW)
        ) u_debounce (
            .CLK25M(CLK25M),
            .Reset (Reset),
            .raw   (raw_vec[c]),
            .level (level_vec[c])
        );
    end

    btn_state_t state     [NUM_CH];
    btn_state_t state_nxt [NUM_CH];
`ifdef BTN_AUTOREPEAT_EN
    logic [CW-1:0] timer     [NUM_CH];
    logic [CW-1:0] timer_nxt [NUM_CH];
`endif

    always_ff @(posedge CLK25M or negedge Reset) begin
        if (!Reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state[c] <= ST_IDLE;
`ifdef BTN_AUTOREPEAT_EN
                timer[c] <= '0;
`endif
            end
        end else begin
            state <= state_nxt;
`ifdef BTN_AUTOREPEAT_EN
            timer <= timer_nxt;
`endif
        end
    end

    // A debounced fall always wins over a repeat that would fire the same clock.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_nxt[c] = state[c];
            event_vec[c] = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            timer_nxt[c] = timer[c];
`endif
            case (state[c])
                ST_IDLE: begin
                    if (level_vec[c]) begin
                        state_nxt[c] = ST_PRESSED;
                        event_vec[c] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        timer_nxt[c] = '0;
`endif
                    end
                end
                ST_PRESSED: begin
                    if (!level_vec[c]) begin
                        state_nxt[c] = ST_IDLE;
`ifdef BTN_AUTOREPEAT_EN
                    end else if (timer[c] == CW'(REPEAT_DELAY - 1)) begin
                        state_nxt[c] = ST_REPEAT;
                        event_vec[c] = 1'b1;
                        timer_nxt[c] = '0;
                    end else begin
                        timer_nxt[c] = timer[c] + 1'b1;
`endif
                    end
                end
`ifdef BTN_AUTOREPEAT_EN
                ST_REPEAT: begin
                    if (!level_vec[c]) begin
                        state_nxt[c] = ST_IDLE;
                    end else if (timer[c] == CW'(REPEAT_PERIOD - 1)) begin
                        event_vec[c] = 1'b1;
                        timer_nxt[c] = '0;
                    end else begin
                        timer_nxt[c] = timer[c] + 1'b1;
                    end
                end
`endif
                default: begin
                    state_nxt[c] = ST_IDLE;
                end
            endcase
        end
    end

    logic          hold_active;
    ch_idx_t       hold_ch;
    logic [CW-1:0] hold_cnt;
    logic [7:0]    event_count;
    logic          accept;
    ch_idx_t       accept_ch;

    // While a request is high only its own channel may restart it; otherwise
    // the highest-priority pending event takes ownership and the rest are lost.
    always_comb begin
        accept    = 1'b0;
        accept_ch = hold_ch;
        if (hold_active) begin
            accept = event_vec[hold_ch];
        end else if (event_vec[CH_L]) begin
            accept    = 1'b1;
            accept_ch = ch_idx_t'(CH_L);
        end else if (event_vec[CH_R]) begin
            accept    = 1'b1;
            accept_ch = ch_idx_t'(CH_R);
        end else if (event_vec[CH_D]) begin
            accept    = 1'b1;
            accept_ch = ch_idx_t'(CH_D);
        end
    end

    always_ff @(posedge CLK25M or negedge Reset) begin
        if (!Reset) begin
            hold_active <= 1'b0;
            hold_ch     <= '0;
            hold_cnt    <= '0;
            event_count <= '0;
        end else if (accept) begin
            hold_active <= 1'b1;
            hold_ch     <= accept_ch;
            hold_cnt    <= '0;
            event_count <= event_count + 8'd1;
        end else if (hold_active) begin
            if (hold_cnt == CW'(HOLD_CYCLES - 1)) begin
                hold_active <= 1'b0;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign bus.buttonL    = hold_active && (hold_ch == ch_idx_t'(CH_L));
    assign bus.buttonR    = hold_active && (hold_ch == ch_idx_t'(CH_R));
    assign bus.buttonD    = hold_active && (hold_ch == ch_idx_t'(CH_D));
    assign bus.levelL     = level_vec[CH_L];
    assign bus.levelR     = level_vec[CH_R];
    assign bus.levelD     = level_vec[CH_D];
    assign bus.eventCount = event_count;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with literal expectations
// plus randomized buttons compared every cycle against a timing-rule model.
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int DEB     = 4;
    localparam int HOLD    = 10;
    localparam int RDELAY  = 30;
    localparam int RPERIOD = 20;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   done  = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    button_conditioner_if bus();

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_DELAY   (RDELAY),
        .REPEAT_PERIOD  (RPERIOD)
    ) dut (
        .CLK25M(clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference model, advanced once per clock edge from the timing rules.
    bit m_s1       [NUM_CH];
    bit m_s2       [NUM_CH];
    bit m_level    [NUM_CH];
    bit m_was_high [NUM_CH];
    bit m_win      [NUM_CH][DEB];
    int m_t0       [NUM_CH];
    int m_edge   = 0;
    int m_owner  = 0;
    int m_remain = 0;
    int m_count  = 0;

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_level[c] = 0; m_was_high[c] = 0; m_t0[c] = 0;
            for (int k = 0; k < DEB; k++) m_win[c][k] = 0;
        end
        m_owner = 0; m_remain = 0; m_count = 0;
    endtask

    task automatic model_step();
        bit raw_now [NUM_CH];
        bit ev      [NUM_CH];
        int prio    [NUM_CH];
        int held;
        bit flip;
        prio[0] = CH_L; prio[1] = CH_R; prio[2] = CH_D;
        raw_now[CH_L] = bus.btnL_raw;
        raw_now[CH_R] = bus.btnR_raw;
        raw_now[CH_D] = bus.btnD_raw;
        m_edge++;
        for (int c = 0; c < NUM_CH; c++) begin
            ev[c] = 0;
            if (m_level[c]) begin
                if (!m_was_high[c]) m_t0[c] = m_edge;
                held = m_edge - m_t0[c];
                if (held == 0) ev[c] = 1;
                else if (AUTOREP && held >= RDELAY && ((held - RDELAY) % RPERIOD) == 0) ev[c] = 1;
            end
            m_was_high[c] = m_level[c];
        end
        if (m_remain > 0) begin
            if (ev[m_owner]) begin
                m_remain = HOLD;
                m_count  = (m_count + 1) % 256;
            end else begin
                m_remain--;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (m_remain == 0 && ev[prio[k]]) begin
                    m_owner  = prio[k];
                    m_remain = HOLD;
                    m_count  = (m_count + 1) % 256;
                end
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = DEB - 1; k > 0; k--) m_win[c][k] = m_win[c][k-1];
            m_win[c][0] = m_s2[c];
            flip = 1;
            for (int k = 0; k < DEB; k++) if (m_win[c][k] == m_level[c]) flip = 0;
            if (flip) m_level[c] = !m_level[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = raw_now[c];
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_clear();
        else        model_step();
    end

    function automatic int exp_button(input int c);
        return (m_remain > 0 && m_owner == c) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        if (!done) begin
            check_output("cmp buttonL",    bus.buttonL,    exp_button(CH_L));
            check_output("cmp buttonR",    bus.buttonR,    exp_button(CH_R));
            check_output("cmp buttonD",    bus.buttonD,    exp_button(CH_D));
            check_output("cmp levelL",     bus.levelL,     m_level[CH_L]);
            check_output("cmp levelR",     bus.levelR,     m_level[CH_R]);
            check_output("cmp levelD",     bus.levelD,     m_level[CH_D]);
            check_output("cmp eventCount", bus.eventCount, m_count);
        end
    end

    task automatic set_raw(input int c, input bit v);
        case (c)
            CH_L:    bus.btnL_raw = v;
            CH_R:    bus.btnR_raw = v;
            default: bus.btnD_raw = v;
        endcase
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        bus.btnL_raw = 0; bus.btnR_raw = 0; bus.btnD_raw = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic apply_stimulus(input int cycles);
        bit cur [NUM_CH];
        int pct;
        for (int c = 0; c < NUM_CH; c++) cur[c] = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #2;
            pct = ((i % 600) < 40) ? 40 : 4;
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 99) < pct) begin
                    cur[c] = !cur[c];
                    set_raw(c, cur[c]);
                end
            end
            if ($urandom_range(0, 1499) == 0) begin
                rst_n = 1'b0;
                @(posedge clk); #2;
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        bus.btnL_raw = 0; bus.btnR_raw = 0; bus.btnD_raw = 0;
        repeat (3) @(posedge clk);
        #3;
        check_output("reset buttonL", bus.buttonL, 0);
        check_output("reset levelL", bus.levelL, 0);
        check_output("reset eventCount", bus.eventCount, 0);

        $display("[TB] single press on L");
        do_reset();
        bus.btnL_raw = 1;
        wait_edges(6);
        check_output("L levelL@6", bus.levelL, 1);
        check_output("L buttonL@6", bus.buttonL, 0);
        wait_edges(1);
        check_output("L buttonL@7", bus.buttonL, 1);
        check_output("L eventCount@7", bus.eventCount, 1);
        wait_edges(9);
        check_output("L buttonL@16", bus.buttonL, 1);
        wait_edges(1);
        check_output("L buttonL@17", bus.buttonL, 0);
        wait_edges(33);
        bus.btnL_raw = 0;
        wait_edges(20);
        check_output("L eventCount end", bus.eventCount, AUTOREP ? 2 : 1);

        $display("[TB] bouncing R");
        do_reset();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            bus.btnR_raw = !bus.btnR_raw;
            repeat (2) @(posedge clk);
            #2;
            seen = seen | bus.buttonR | bus.levelR;
        end
        bus.btnR_raw = 0;
        wait_edges(10);
        check_output("bounce R seen", seen, 0);
        check_output("bounce eventCount", bus.eventCount, 0);

        $display("[TB] simultaneous L and D");
        do_reset();
        bus.btnL_raw = 1; bus.btnD_raw = 1;
        wait_edges(7);
        check_output("LD buttonL@7", bus.buttonL, 1);
        check_output("LD buttonD@7", bus.buttonD, 0);
        wait_edges(9);
        check_output("LD buttonL@16", bus.buttonL, 1);
        wait_edges(1);
        check_output("LD buttonL@17", bus.buttonL, 0);
        check_output("LD buttonD@17", bus.buttonD, 0);
        check_output("LD eventCount", bus.eventCount, 1);
        bus.btnL_raw = 0; bus.btnD_raw = 0;
        wait_edges(20);

        $display("[TB] long hold on D");
        do_reset();
        bus.btnD_raw = 1;
        wait_edges(7);
        check_output("D buttonD@7", bus.buttonD, 1);
        check_output("D eventCount@7", bus.eventCount, 1);
        wait_edges(30);
        check_output("D buttonD@37", bus.buttonD, AUTOREP ? 1 : 0);
        check_output("D eventCount@37", bus.eventCount, AUTOREP ? 2 : 1);
        wait_edges(63);
        bus.btnD_raw = 0;
        wait_edges(20);
        check_output("D eventCount end", bus.eventCount, AUTOREP ? 5 : 1);

        $display("[TB] reset during hold");
        do_reset();
        bus.btnL_raw = 1;
        wait_edges(10);
        check_output("RST buttonL before", bus.buttonL, 1);
        rst_n = 1'b0;
        #1;
        check_output("RST buttonL", bus.buttonL, 0);
        check_output("RST levelL", bus.levelL, 0);
        check_output("RST eventCount", bus.eventCount, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_edges(6);
        check_output("RST buttonL@6", bus.buttonL, 0);
        check_output("RST levelL@6", bus.levelL, 1);
        wait_edges(1);
        check_output("RST buttonL@7", bus.buttonL, 1);
        check_output("RST eventCount@7", bus.eventCount, 1);
        bus.btnL_raw = 0;
        wait_edges(20);

        $display("[TB] randomized buttons");
        do_reset();
        apply_stimulus(4000);
        bus.btnL_raw = 0; bus.btnR_raw = 0; bus.btnD_raw = 0;
        wait_edges(40);

        done = 1'b1;
        #10;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
